alert_sched_57: RTL and testbench

Priority scheduler for the clock's shared LED/buzzer alert resource. It arbitrates between alarm, hourly-chime and game requests and drives `game_e_57`, `sound_e_57` and `sound_model_57` into the LED/buzzer driver. It times each alert in 1 Hz ticks and reports alarm completion to the alarm-compare logic.

---
 rtl/alert_sched_57.sv | 206 ++++++++++++++++++++
 tb/tb_alert_sched_57.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alert_sched_57.sv
// alert_sched_57: priority scheduler for the shared LED/buzzer alert resource.
// Arbitrates alarm > chime > game requests and times alarm/chime in 1 Hz ticks.
// Every hand-off between two active states passes through GAP for one clock,
// so the driver always sees its enable fall.
// Optional feature macro: ALERT_SNOOZE_EN (alarm snooze timer and snooze counter).
//
// state | meaning
// IDLE  | nothing active, waiting for a pending flag or game_req_57
// GAP   | one-clock blank between alerts, then re-arbitrate
// ALARM | alarm sounding (sound_e_57=1, sound_model_57=0)
// CHIME | hourly chime sounding (sound_e_57=1, sound_model_57=1)
// GAME  | game LED pattern enabled

module alert_sched_57 #(
   parameter int unsigned ALARM_SEC  = 256,
   parameter int unsigned CHIME_SEC  = 32,
   parameter int unsigned SNOOZE_SEC = 300,
   parameter int unsigned SNOOZE_MAX = 3
) (
   input  logic clk_50m_57,
   input  logic rst_57,
   input  logic clk_1_57,
   input  logic alarm_req_57,
   input  logic chime_req_57,
   input  logic game_req_57,
   input  logic stop_57,
   output logic game_e_57,
   output logic sound_e_57,
   output logic sound_model_57,
   output logic alarm_done_57,
   output logic alarm_stopped_57
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GAP   = 3'd1,
      ST_ALARM = 3'd2,
      ST_CHIME = 3'd3,
      ST_GAME  = 3'd4
   } state_t;

   localparam logic [9:0] ALARM_LAST = 10'(ALARM_SEC - 1);
   localparam logic [9:0] CHIME_LAST = 10'(CHIME_SEC - 1);

   state_t     st_q, st_d;
   logic       clk1_q;
   logic       tick;
   logic       alarm_pend_q, alarm_pend_d;
   logic       chime_pend_q, chime_pend_d;
   logic [9:0] cnt_q, cnt_d;
   logic       dur_hit;
   logic       alarm_exit;
   logic       game_e_q, game_e_d;
   logic       sound_e_q, sound_e_d;
   logic       model_q, model_d;
   logic       done_q, done_d;
   logic       stopped_q, stopped_d;

   // snooze hooks; tied off when the snooze feature is not built
   logic       snz_start;
   logic       snz_cancel;
   logic       snz_pend_set;

   assign tick = clk_1_57 & ~clk1_q;

   assign dur_hit = tick &&
                    (((st_q == ST_ALARM) && (cnt_q == ALARM_LAST)) ||
                     ((st_q == ST_CHIME) && (cnt_q == CHIME_LAST)));

   // stop takes precedence over a timeout landing on the same edge
   assign alarm_exit = (st_q == ST_ALARM) && (stop_57 || dur_hit);

`ifdef ALERT_SNOOZE_EN
   logic       snz_act_q, snz_act_d;
   logic [9:0] snz_tmr_q, snz_tmr_d;
   logic [2:0] snz_used_q, snz_used_d;
   logic       snz_expire;

   assign snz_start    = (st_q == ST_ALARM) && stop_57 && (snz_used_q < 3'(SNOOZE_MAX));
   assign snz_cancel   = snz_act_q && stop_57 && (st_q != ST_CHIME) && (st_q != ST_ALARM);
   assign snz_expire   = snz_act_q && tick && (snz_tmr_q == 10'd1);
   assign snz_pend_set = snz_expire && !snz_cancel;

   // snooze down-counter and per-alarm snooze count
   always_comb begin
      snz_act_d  = snz_act_q;
      snz_tmr_d  = snz_tmr_q;
      snz_used_d = snz_used_q;
      if (snz_start) begin
         snz_act_d = 1'b1;
         snz_tmr_d = 10'(SNOOZE_SEC);
      end else if (snz_cancel) begin
         snz_act_d  = 1'b0;
         snz_used_d = 3'd0;
      end else if (snz_expire) begin
         snz_act_d  = 1'b0;
         snz_used_d = snz_used_q + 3'd1;
      end else if (snz_act_q && tick) begin
         snz_tmr_d = snz_tmr_q - 10'd1;
      end
      if (alarm_exit && !snz_start) begin
         snz_used_d = 3'd0;
      end
   end

   // snooze registers
   always_ff @(posedge clk_50m_57) begin
      if (rst_57) begin
         snz_act_q  <= 1'b0;
         snz_tmr_q  <= 10'd0;
         snz_used_q <= 3'd0;
      end else begin
         snz_act_q  <= snz_act_d;
         snz_tmr_q  <= snz_tmr_d;
         snz_used_q <= snz_used_d;
      end
   end
`else
   logic unused_snz;

   assign snz_start    = 1'b0;
   assign snz_cancel   = 1'b0;
   assign snz_pend_set = 1'b0;
   assign unused_snz   = ^{10'(SNOOZE_SEC), 3'(SNOOZE_MAX)};
`endif

   // next state, pending flags, tick counter and registered-output decode
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE, ST_GAP: begin
            if (alarm_pend_q)      st_d = ST_ALARM;
            else if (chime_pend_q) st_d = ST_CHIME;
            else if (game_req_57)  st_d = ST_GAME;
            else                   st_d = ST_IDLE;
         end
         ST_ALARM: begin
            if (stop_57 || dur_hit) st_d = ST_GAP;
         end
         ST_CHIME: begin
            if (stop_57 || dur_hit || alarm_pend_q) st_d = ST_GAP;
         end
         ST_GAME: begin
            if (alarm_pend_q || chime_pend_q || !game_req_57) st_d = ST_GAP;
         end
         default: st_d = ST_IDLE;
      endcase

      // a request for the state already running merges into it
      alarm_pend_d = alarm_pend_q | (alarm_req_57 && (st_q != ST_ALARM)) | snz_pend_set;
      chime_pend_d = chime_pend_q | (chime_req_57 && (st_q != ST_CHIME));
      if ((st_d == ST_ALARM) && (st_q != ST_ALARM)) alarm_pend_d = 1'b0;
      if ((st_d == ST_CHIME) && (st_q != ST_CHIME)) chime_pend_d = 1'b0;

      cnt_d = cnt_q;
      if (((st_d == ST_ALARM) || (st_d == ST_CHIME)) && (st_d != st_q)) begin
         cnt_d = 10'd0;
      end else if (tick && ((st_q == ST_ALARM) || (st_q == ST_CHIME))) begin
         cnt_d = cnt_q + 10'd1;
      end

      game_e_d  = (st_d == ST_GAME);
      sound_e_d = (st_d == ST_ALARM) || (st_d == ST_CHIME);
      model_d   = model_q;
      if (st_d == ST_ALARM) model_d = 1'b0;
      if (st_d == ST_CHIME) model_d = 1'b1;

      done_d    = (alarm_exit && !snz_start) || snz_cancel;
      stopped_d = stopped_q;
      if (done_d) stopped_d = snz_cancel || stop_57;
   end

   // state, flags, counter, tick sampler and output registers
   always_ff @(posedge clk_50m_57) begin
      if (rst_57) begin
         st_q         <= ST_IDLE;
         clk1_q       <= 1'b0;
         alarm_pend_q <= 1'b0;
         chime_pend_q <= 1'b0;
         cnt_q        <= 10'd0;
         game_e_q     <= 1'b0;
         sound_e_q    <= 1'b0;
         model_q      <= 1'b0;
         done_q       <= 1'b0;
         stopped_q    <= 1'b0;
      end else begin
         st_q         <= st_d;
         clk1_q       <= clk_1_57;
         alarm_pend_q <= alarm_pend_d;
         chime_pend_q <= chime_pend_d;
         cnt_q        <= cnt_d;
         game_e_q     <= game_e_d;
         sound_e_q    <= sound_e_d;
         model_q      <= model_d;
         done_q       <= done_d;
         stopped_q    <= stopped_d;
      end
   end

   assign game_e_57        = game_e_q;
   assign sound_e_57       = sound_e_q;
   assign sound_model_57   = model_q;
   assign alarm_done_57    = done_q;
   assign alarm_stopped_57 = stopped_q;

endmodule

// File: tb/tb_alert_sched_57.sv
// Scoreboard bench for alert_sched_57. The driver pushes each expected output
// change (vector {game_e, sound_e, sound_model, done, stopped} and the cycle it
// must appear on); the monitor compares every observed output change against it.
// With ALERT_SNOOZE_EN defined the snooze sequence is exercised as well.

module tb_alert_sched_57;

   logic clk = 1'b0;
   logic rst, clk1, alarm_req, chime_req, game_req, stop;
   logic game_e, sound_e, sound_model, alarm_done, alarm_stopped;

   typedef struct {
      logic [4:0] v;
      int         t;
   } ev_t;

   ev_t        q[$];
   ev_t        mon_e;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic       mon_en = 1'b0;
   logic [4:0] prev_vec = 5'b0;
   logic [4:0] dut_vec;
   logic       stp, mdl;
   int         t;

   alert_sched_57 #(
      .ALARM_SEC (4),
      .CHIME_SEC (32),
      .SNOOZE_SEC(5),
      .SNOOZE_MAX(2)
   ) dut (
      .clk_50m_57      (clk),
      .rst_57          (rst),
      .clk_1_57        (clk1),
      .alarm_req_57    (alarm_req),
      .chime_req_57    (chime_req),
      .game_req_57     (game_req),
      .stop_57         (stop),
      .game_e_57       (game_e),
      .sound_e_57      (sound_e),
      .sound_model_57  (sound_model),
      .alarm_done_57   (alarm_done),
      .alarm_stopped_57(alarm_stopped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign dut_vec = {game_e, sound_e, sound_model, alarm_done, alarm_stopped};

   // monitor: every change of the output vector must match the next expectation
   always @(posedge clk) begin
      #1;
      if (mon_en && (dut_vec !== prev_vec)) begin
         prev_vec = dut_vec;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cycle=%0d got=%b", cyc, dut_vec);
         end else begin
            mon_e = q.pop_front();
            if ((mon_e.v !== dut_vec) || (mon_e.t != cyc)) begin
               failures++;
               $display("FAIL event got=%b@%0d expected=%b@%0d", dut_vec, cyc, mon_e.v, mon_e.t);
            end
         end
      end
   end

   function automatic logic [4:0] v(input logic g, input logic s, input logic m,
                                    input logic d, input logic st);
      return {g, s, m, d, st};
   endfunction

   task automatic expect_at(input logic [4:0] vec, input int when);
      ev_t e;
      e.v = vec;
      e.t = when;
      q.push_back(e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a negedge; inputs sampled on the next posedge
   task automatic pulse(input logic a, input logic c, input logic s);
      alarm_req = a;
      chime_req = c;
      stop      = s;
      @(negedge clk);
      alarm_req = 1'b0;
      chime_req = 1'b0;
      stop      = 1'b0;
   endtask

   // rising edge of clk1 at the next posedge is the tick edge
   task automatic tick_one();
      clk1 = 1'b1;
      @(negedge clk);
      clk1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick_one();
   endtask

   initial begin
      rst = 1'b1; clk1 = 1'b0; alarm_req = 1'b0; chime_req = 1'b0;
      game_req = 1'b0; stop = 1'b0;
      stp = 1'b0; mdl = 1'b0;
      wait_n(3);
      checks++;
      if (dut_vec !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b expected=%b", dut_vec, 5'b0);
      end
      rst = 1'b0;
      mon_en = 1'b1;
      wait_n(2);

      // chime only: enable two clocks after request, off on the 32nd tick
      t = cyc; expect_at(v(0,1,1,0,stp), t + 2); mdl = 1'b1;
      pulse(0, 1, 0);
      wait_n(3); tick_n(31);
      t = cyc; expect_at(v(0,0,1,0,stp), t + 1);
      tick_one(); wait_n(4);

      // stop in IDLE does nothing
      pulse(0, 0, 1); wait_n(4);

      // game, preempted by alarm, alarm stopped, game resumes
      t = cyc; expect_at(v(1,0,mdl,0,stp), t + 1);
      game_req = 1'b1; wait_n(4);
      t = cyc; expect_at(v(0,0,mdl,0,stp), t + 2); expect_at(v(0,1,0,0,stp), t + 3);
      mdl = 1'b0;
      pulse(1, 0, 0); wait_n(4);
`ifdef ALERT_SNOOZE_EN
      t = cyc; expect_at(v(0,0,0,0,stp), t + 1); expect_at(v(1,0,0,0,stp), t + 2);
      pulse(0, 0, 1); wait_n(4);
      t = cyc; expect_at(v(1,0,0,1,1), t + 1); expect_at(v(1,0,0,0,1), t + 2);
      stp = 1'b1;
      pulse(0, 0, 1); wait_n(4);
`else
      t = cyc; expect_at(v(0,0,0,1,1), t + 1); expect_at(v(1,0,0,0,1), t + 2);
      stp = 1'b1;
      pulse(0, 0, 1); wait_n(4);
`endif
      t = cyc; expect_at(v(0,0,0,0,stp), t + 1);
      game_req = 1'b0; wait_n(4);

      // simultaneous alarm and chime: alarm times out after 4 ticks, then chime
      t = cyc; expect_at(v(0,1,0,0,stp), t + 2);
      pulse(1, 1, 0); wait_n(3); tick_n(3);
      t = cyc; expect_at(v(0,0,0,1,0), t + 1); expect_at(v(0,1,1,0,0), t + 2);
      stp = 1'b0; mdl = 1'b1;
      tick_one(); wait_n(3); tick_n(31);
      t = cyc; expect_at(v(0,0,1,0,0), t + 1);
      tick_one(); wait_n(4);

      // repeat alarm during ALARM merges without restarting the duration
      t = cyc; expect_at(v(0,1,0,0,0), t + 2); mdl = 1'b0;
      pulse(1, 0, 0); wait_n(3); tick_n(2);
      pulse(1, 0, 0); wait_n(2); tick_n(1);
      t = cyc; expect_at(v(0,0,0,1,0), t + 1); expect_at(v(0,0,0,0,0), t + 2);
      tick_one(); wait_n(6);

      // repeat chime during CHIME merges without restarting
      t = cyc; expect_at(v(0,1,1,0,0), t + 2); mdl = 1'b1;
      pulse(0, 1, 0); wait_n(3); tick_n(10);
      pulse(0, 1, 0); wait_n(2); tick_n(21);
      t = cyc; expect_at(v(0,0,1,0,0), t + 1);
      tick_one(); wait_n(8);

      // stop ends a chime
      t = cyc; expect_at(v(0,1,1,0,0), t + 2);
      pulse(0, 1, 0); wait_n(3); tick_n(5);
      t = cyc; expect_at(v(0,0,1,0,0), t + 1);
      pulse(0, 0, 1); wait_n(4);

      // alarm preempts chime; the chime is dropped
      t = cyc; expect_at(v(0,1,1,0,0), t + 2);
      pulse(0, 1, 0); wait_n(3);
      t = cyc; expect_at(v(0,0,1,0,0), t + 2); expect_at(v(0,1,0,0,0), t + 3);
      mdl = 1'b0;
      pulse(1, 0, 0); wait_n(3); tick_n(3);
      t = cyc; expect_at(v(0,0,0,1,0), t + 1); expect_at(v(0,0,0,0,0), t + 2);
      tick_one(); wait_n(6); tick_n(4); wait_n(4);

      // reset mid-alarm with a chime pending: outputs drop, no chime afterwards
      t = cyc; expect_at(v(0,1,0,0,0), t + 2);
      pulse(1, 0, 0); wait_n(3);
      pulse(0, 1, 0); wait_n(2);
      t = cyc; expect_at(v(0,0,0,0,0), t + 1);
      rst = 1'b1; wait_n(2); rst = 1'b0;
      wait_n(4); tick_n(6); wait_n(6);

`ifdef ALERT_SNOOZE_EN
      // snooze twice (5 ticks each), third stop is final
      t = cyc; expect_at(v(0,1,0,0,0), t + 2);
      pulse(1, 0, 0); wait_n(3);
      for (int k = 0; k < 2; k++) begin
         t = cyc; expect_at(v(0,0,0,0,0), t + 1);
         pulse(0, 0, 1); wait_n(3); tick_n(4);
         t = cyc; expect_at(v(0,1,0,0,0), t + 2);
         tick_one(); wait_n(3);
      end
      t = cyc; expect_at(v(0,0,0,1,1), t + 1); expect_at(v(0,0,0,0,1), t + 2);
      pulse(0, 0, 1); wait_n(4); tick_n(7); wait_n(4);
`endif

      wait_n(4);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL missing_events pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
